ssd_source_scheduler: RTL and testbench

Time-shares the 4-digit seven-segment display between three 16-bit requesters, for example operand A, operand B and the adder/multiplier result. It grants requesters round-robin, shows each one for a programmable dwell time, and supports a hold/freeze input. It drives the nibble inputs and enables of four per-digit hex decoders, which in turn feed the display-multiplexing controller. It sits between the arithmetic datapath and the display path.

---
 rtl/ssd_sched_pkg.sv | 36 +++
 rtl/ssd_source_scheduler_rr_pick.sv | 36 +++
 rtl/ssd_source_scheduler.sv | 128 ++++++++++++
 tb/tb_ssd_source_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ssd_sched_pkg.sv
// rtl/ssd_sched_pkg.sv - shared types, constants and helpers for the display source scheduler
// Contents:
//   state_t  : scheduler FSM encoding (S_IDLE, S_SHOW)
//   NUM_SRC  : number of requesters sharing the display
//   SRC_IDLE : src code reported when nothing is shown
//   rr_next  : next index in round-robin order (0 -> 1 -> 2 -> 0)
//   req_at   : request bit for a source index (0 for the idle code)
package ssd_sched_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SHOW = 1'b1
    } state_t;

    localparam int         NUM_SRC  = 3;
    localparam logic [1:0] SRC_IDLE = 2'b11;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

    // Explicit decode keeps an index of 3 (idle code) from selecting past the vector.
    function automatic logic req_at(input logic [NUM_SRC-1:0] req, input logic [1:0] idx);
        case (idx)
            2'd0:    req_at = req[0];
            2'd1:    req_at = req[1];
            2'd2:    req_at = req[2];
            default: req_at = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ssd_source_scheduler_rr_pick.sv
// rtl/ssd_source_scheduler_rr_pick.sv - combinational round-robin picker over three requesters
// Ports:
//   req   in  3 : request levels
//   last  in  2 : most recently granted index
//   valid out 1 : some request is pending
//   idx   out 2 : first requester after last (wrapping, last itself checked last)
module rr_pick
    import ssd_sched_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         last,
    output logic               valid,
    output logic [1:0]         idx
);

    logic [1:0] c0, c1, c2;

    assign c0 = rr_next(last);
    assign c1 = rr_next(c0);
    assign c2 = rr_next(c1);

    always_comb begin
        valid = 1'b1;
        idx   = SRC_IDLE;
        if (req_at(req, c0)) begin
            idx = c0;
        end else if (req_at(req, c1)) begin
            idx = c1;
        end else if (req_at(req, c2)) begin
            idx = c2;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/ssd_source_scheduler.sv
// rtl/ssd_source_scheduler.sv - round-robin time-sharing of the 4-digit display between three sources
// Parameters:
//   DWELL_CYCLES : cycles each granted source is shown (>= 1)
//   BLANK_LZ     : 1 blanks leading-zero digits
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   req[2:0]             : level requests from the three sources
//   val0, val1, val2     : 16-bit values, nibble k drives digit k
//   hold                 : keep the current source while its request stays high
//   disp_val[15:0]       : nibbles for the four hex decoders (registered)
//   disp_en[3:0]         : per-digit decoder enables (registered)
//   src[1:0]             : shown source, 2'b11 when idle (registered)
//   switch_pulse         : one-cycle pulse whenever src changes
module ssd_source_scheduler
    import ssd_sched_pkg::*;
#(
    parameter int DWELL_CYCLES = 100_000_000,
    parameter bit BLANK_LZ     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic [15:0]        val0,
    input  logic [15:0]        val1,
    input  logic [15:0]        val2,
    input  logic               hold,
    output logic [15:0]        disp_val,
    output logic [3:0]         disp_en,
    output logic [1:0]         src,
    output logic               switch_pulse
);

    localparam int            CW     = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DWELL_CYCLES - 1);

    state_t        state, nxt_state;
    logic [CW-1:0] cnt;
    logic [1:0]    last;
    logic [1:0]    nxt_src;
    logic          reload;
    logic          pick_valid;
    logic [1:0]    pick_idx;
    logic [15:0]   sel_val;
    logic [3:0]    lz_mask;
    logic [3:0]    sel_en;

    rr_pick u_rr_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A dropped request overrides both hold and the counter; at expiry without
    // hold the picker may legitimately return the current source again.
    always_comb begin
        nxt_state = state;
        nxt_src   = src;
        reload    = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    nxt_state = S_SHOW;
                    nxt_src   = pick_idx;
                    reload    = 1'b1;
                end
            end
            S_SHOW: begin
                if (!req_at(req, src) || (cnt == '0 && !hold)) begin
                    if (pick_valid) begin
                        nxt_src = pick_idx;
                        reload  = 1'b1;
                    end else begin
                        nxt_state = S_IDLE;
                        nxt_src   = SRC_IDLE;
                    end
                end else if (cnt == '0) begin
                    reload = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        case (nxt_src)
            2'd0:    sel_val = val0;
            2'd1:    sel_val = val1;
            2'd2:    sel_val = val2;
            default: sel_val = 16'h0000;
        endcase
    end

    // Digit k lit when any nibble at or above k is non-zero; digit 0 always lit.
    assign lz_mask[3] = |sel_val[15:12];
    assign lz_mask[2] = lz_mask[3] | (|sel_val[11:8]);
    assign lz_mask[1] = lz_mask[2] | (|sel_val[7:4]);
    assign lz_mask[0] = 1'b1;
    assign sel_en     = BLANK_LZ ? lz_mask : 4'b1111;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            src          <= SRC_IDLE;
            cnt          <= '0;
            last         <= 2'd2;
            disp_val     <= 16'h0000;
            disp_en      <= 4'b0000;
            switch_pulse <= 1'b0;
        end else begin
            state        <= nxt_state;
            src          <= nxt_src;
            switch_pulse <= (nxt_src != src);
            if (reload) begin
                cnt <= RELOAD;
            end else if (nxt_state == S_IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt - CW'(1);
            end
            if (nxt_state == S_SHOW) begin
                last <= nxt_src;
            end
            disp_val <= sel_val;
            disp_en  <= (nxt_state == S_SHOW) ? sel_en : 4'b0000;
        end
    end

endmodule

// File: tb/tb_ssd_source_scheduler.sv
// tb/tb_ssd_source_scheduler.sv - self-checking bench for ssd_source_scheduler
module tb_ssd_source_scheduler;

    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = 3'b000;
    logic        hold = 1'b0;
    logic [15:0] val0 = 16'h12AB;
    logic [15:0] val1 = 16'h3400;
    logic [15:0] val2 = 16'h0005;

    logic [15:0] disp_val, lz_val, d1_val;
    logic [3:0]  disp_en, lz_en, d1_en;
    logic [1:0]  src, lz_src, d1_src;
    logic        switch_pulse, lz_pulse, d1_pulse;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ssd_source_scheduler #(.DWELL_CYCLES(DW), .BLANK_LZ(1'b0)) dut (
        .clk(clk), .rst(rst), .req(req), .val0(val0), .val1(val1), .val2(val2),
        .hold(hold), .disp_val(disp_val), .disp_en(disp_en), .src(src),
        .switch_pulse(switch_pulse)
    );

    ssd_source_scheduler #(.DWELL_CYCLES(DW), .BLANK_LZ(1'b1)) dut_lz (
        .clk(clk), .rst(rst), .req(req), .val0(val0), .val1(val1), .val2(val2),
        .hold(hold), .disp_val(lz_val), .disp_en(lz_en), .src(lz_src),
        .switch_pulse(lz_pulse)
    );

    ssd_source_scheduler #(.DWELL_CYCLES(1), .BLANK_LZ(1'b0)) dut1 (
        .clk(clk), .rst(rst), .req(req), .val0(val0), .val1(val1), .val2(val2),
        .hold(hold), .disp_val(d1_val), .disp_en(d1_en), .src(d1_src),
        .switch_pulse(d1_pulse)
    );

    typedef struct {
        int          n;
        logic [2:0]  req;
        logic        hold;
        logic [15:0] v0;
        logic [1:0]  src;
        logic [15:0] dval;
        logic [3:0]  en;
        logic [3:0]  en_lz;
        logic        pulse;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic [1:0] e_src, input logic [15:0] e_val,
                            input logic [3:0] e_en, input logic [3:0] e_en_lz, input logic e_p);
        chk({tag, " src"},      16'(src),          16'(e_src));
        chk({tag, " disp_val"}, disp_val,          e_val);
        chk({tag, " disp_en"},  16'(disp_en),      16'(e_en));
        chk({tag, " pulse"},    16'(switch_pulse), 16'(e_p));
        chk({tag, " lz_src"},   16'(lz_src),       16'(e_src));
        chk({tag, " lz_val"},   lz_val,            e_val);
        chk({tag, " lz_en"},    16'(lz_en),        16'(e_en_lz));
        chk({tag, " lz_pulse"}, 16'(lz_pulse),     16'(e_p));
    endtask

    initial begin
        //        n   req    hold v0        src  dval      en    en_lz pulse
        vecs.push_back('{1,  3'b000, 1'b0, 16'h12AB, 2'd3, 16'h0000, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{4,  3'b001, 1'b0, 16'h12AB, 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b1});
        vecs.push_back('{1,  3'b001, 1'b0, 16'h12AB, 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b0});
        vecs.push_back('{3,  3'b111, 1'b0, 16'h12AB, 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b0});
        vecs.push_back('{4,  3'b111, 1'b0, 16'h12AB, 2'd1, 16'h3400, 4'hF, 4'hF, 1'b1});
        vecs.push_back('{4,  3'b111, 1'b0, 16'h12AB, 2'd2, 16'h0005, 4'hF, 4'h1, 1'b1});
        vecs.push_back('{4,  3'b111, 1'b0, 16'h12AB, 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b1});
        vecs.push_back('{4,  3'b111, 1'b0, 16'h12AB, 2'd1, 16'h3400, 4'hF, 4'hF, 1'b1});
        vecs.push_back('{4,  3'b111, 1'b0, 16'h12AB, 2'd2, 16'h0005, 4'hF, 4'h1, 1'b1});
        vecs.push_back('{1,  3'b111, 1'b0, 16'h12AB, 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b1});
        vecs.push_back('{3,  3'b101, 1'b0, 16'h12AB, 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b0});
        vecs.push_back('{4,  3'b101, 1'b0, 16'h12AB, 2'd2, 16'h0005, 4'hF, 4'h1, 1'b1});
        vecs.push_back('{1,  3'b101, 1'b0, 16'h12AB, 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b1});
        vecs.push_back('{3,  3'b111, 1'b0, 16'h12AB, 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b0});
        vecs.push_back('{1,  3'b111, 1'b0, 16'h12AB, 2'd1, 16'h3400, 4'hF, 4'hF, 1'b1});
        vecs.push_back('{24, 3'b111, 1'b1, 16'h12AB, 2'd1, 16'h3400, 4'hF, 4'hF, 1'b0});
        vecs.push_back('{1,  3'b101, 1'b1, 16'h12AB, 2'd2, 16'h0005, 4'hF, 4'h1, 1'b1});
        vecs.push_back('{1,  3'b000, 1'b1, 16'h12AB, 2'd3, 16'h0000, 4'h0, 4'h0, 1'b1});
        vecs.push_back('{2,  3'b000, 1'b1, 16'h12AB, 2'd3, 16'h0000, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1,  3'b001, 1'b0, 16'h0030, 2'd0, 16'h0030, 4'hF, 4'h3, 1'b1});
        vecs.push_back('{1,  3'b001, 1'b0, 16'h0000, 2'd0, 16'h0000, 4'hF, 4'h1, 1'b0});
        vecs.push_back('{1,  3'b001, 1'b0, 16'h8000, 2'd0, 16'h8000, 4'hF, 4'hF, 1'b0});
        vecs.push_back('{1,  3'b001, 1'b0, 16'h12AB, 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b0});

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk_main("reset", 2'd3, 16'h0000, 4'h0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Table-driven scenarios: each row held for n cycles, pulse expected only on its first
        for (int r = 0; r < vecs.size(); r++) begin
            req  = vecs[r].req;
            hold = vecs[r].hold;
            val0 = vecs[r].v0;
            for (int j = 0; j < vecs[r].n; j++) begin
                step();
                chk_main($sformatf("row%0d.%0d", r, j), vecs[r].src, vecs[r].dval,
                         vecs[r].en, vecs[r].en_lz, (j == 0) ? vecs[r].pulse : 1'b0);
            end
        end

        // Asynchronous reset in cycle 2 of a dwell
        req = 3'b001; hold = 1'b0;
        step();
        chk_main("rst_pre1", 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b0);
        step();
        chk_main("rst_pre2", 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk_main("rst_async", 2'd3, 16'h0000, 4'h0, 4'h0, 1'b0);
        step();
        chk_main("rst_held", 2'd3, 16'h0000, 4'h0, 4'h0, 1'b0);
        rst = 1'b0;
        req = 3'b111;

        // First grant after reset favours source 0; DWELL_CYCLES=1 rotates every cycle
        step();
        chk_main("post_rst", 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b1);
        chk("d1_a src",   16'(d1_src),   16'd0);
        chk("d1_a pulse", 16'(d1_pulse), 16'd1);
        chk("d1_a val",   d1_val,        16'h12AB);
        chk("d1_a en",    16'(d1_en),    16'hF);
        step();
        chk_main("post_rst2", 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b0);
        chk("d1_b src",   16'(d1_src),   16'd1);
        chk("d1_b pulse", 16'(d1_pulse), 16'd1);
        chk("d1_b val",   d1_val,        16'h3400);
        step();
        chk("d1_c src",   16'(d1_src),   16'd2);
        chk("d1_c val",   d1_val,        16'h0005);
        step();
        chk("d1_d src",   16'(d1_src),   16'd0);
        chk("d1_d pulse", 16'(d1_pulse), 16'd1);
        chk_main("post_rst4", 2'd0, 16'h12AB, 4'hF, 4'hF, 1'b0);
        step();
        chk_main("post_rst5", 2'd1, 16'h3400, 4'hF, 4'hF, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
